// File: rtl/glb_pkg.sv
// glb_pkg: shared clear-FSM state type and buffer geometry for the global buffer responder
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package glb_pkg;
  localparam int GLB_DEPTH = 16384;
  localparam int GLB_WORD_AW = 14;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
endpackage

// File: rtl/glb_if.sv
// glb_if: accelerator-side read, write and clear signals of the global buffer
interface glb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          glb_read_ready;
  logic [AW-1:0] glb_read_addr;
  logic          glb_read_valid;
  logic [DW-1:0] glb_read_data;
  logic          glb_write_valid;
  logic [AW-1:0] glb_write_addr;
  logic [DW-1:0] glb_write_data;
  logic          WEB;
  logic [DW-1:0] BWEB;
  logic          glb_write_ready;
  logic          clr_start;
  logic [AW-1:0] clr_base;
  logic [15:0]   clr_words;
  logic          clr_busy;
  logic          clr_done;
  modport master (
    output glb_read_ready, glb_read_addr, glb_write_valid, glb_write_addr, glb_write_data,
           WEB, BWEB, clr_start, clr_base, clr_words,
    input  glb_read_valid, glb_read_data, glb_write_ready, clr_busy, clr_done
  );
  modport slave (
    input  glb_read_ready, glb_read_addr, glb_write_valid, glb_write_addr, glb_write_data,
           WEB, BWEB, clr_start, clr_base, clr_words,
    output glb_read_valid, glb_read_data, glb_write_ready, clr_busy, clr_done
  );
endinterface

// File: rtl/glb_clear_fsm.sv
// glb_clear_fsm: walks a word pointer from the clear base for clr_words cycles, then pulses done
module glb_clear_fsm
  import glb_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DEPTH = GLB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_start_i,
  input  logic [ADDR_WIDTH-1:0]  clr_base_i,
  input  logic [15:0]            clr_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   oob_o,
  output logic [GLB_WORD_AW-1:0] word_o
);
  localparam int WA = ADDR_WIDTH - 2;
  clr_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [WA-1:0] ptr_q, ptr_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && clr_start_i) begin
      state_d = (clr_words_i != 16'd0) ? CLEAR : DONE;
      cnt_d = clr_words_i;
      ptr_d = WA'(clr_base_i >> 2);
    end else if (state_q == CLEAR) begin
      state_d = (cnt_q == 16'd1) ? DONE : CLEAR;
      cnt_d = cnt_q - 16'd1;
      ptr_d = ptr_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // the pointer is kept full width so it never wraps back into the array
  assign busy_o = state_q == CLEAR;
  assign done_o = state_q == DONE;
  assign oob_o = ptr_q >= WA'(DEPTH);
  assign word_o = ptr_q[GLB_WORD_AW-1:0];
endmodule

// File: rtl/glb_responder.sv
// glb_responder: global buffer front end for a 1-cycle SRAM macro with RAW bypass,
// address checking and a background clear engine
module glb_responder
  import glb_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH = GLB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  glb_if.slave                   bus,
  output logic                   sram_CS,
  output logic                   sram_WEB,
  output logic [DATA_WIDTH-1:0]  sram_BWEB,
  output logic                   sram_RE,
  output logic [GLB_WORD_AW-1:0] sram_R_ADDR,
  output logic [GLB_WORD_AW-1:0] sram_W_ADDR,
  output logic [DATA_WIDTH-1:0]  sram_D_IN,
  input  logic [DATA_WIDTH-1:0]  sram_D_OUT,
  output logic                   err_addr
);
  localparam int WA = ADDR_WIDTH - 2;
  logic [WA-1:0] rd_word, wr_word;
  logic [GLB_WORD_AW-1:0] clr_word;
  logic rd_oob, wr_oob, clr_oob, clr_busy, clr_done;
  logic rd_go, wr_try, wr_go, clr_go, byp_d, err_d;
  logic rvalid_q, roob_q, byp_q, err_q;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_mask_q;
  glb_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_clr (
    .clk(clk),
    .rst(rst),
    .clr_start_i(bus.clr_start),
    .clr_base_i(bus.clr_base),
    .clr_words_i(bus.clr_words),
    .busy_o(clr_busy),
    .done_o(clr_done),
    .oob_o(clr_oob),
    .word_o(clr_word)
  );
  assign rd_word = WA'(bus.glb_read_addr >> 2);
  assign wr_word = WA'(bus.glb_write_addr >> 2);
  assign rd_oob = rd_word >= WA'(DEPTH);
  assign wr_oob = wr_word >= WA'(DEPTH);
  assign rd_go = rst & bus.glb_read_ready;
  assign wr_try = rst & bus.glb_write_valid & bus.glb_write_ready & ~bus.WEB;
  assign wr_go = wr_try & ~wr_oob;
  assign clr_go = rst & clr_busy & ~clr_oob;
  assign err_d = (rd_go & (rd_oob | (|bus.glb_read_addr[1:0])))
               | (wr_try & (wr_oob | (|bus.glb_write_addr[1:0])))
               | (rst & clr_busy & clr_oob);
  assign sram_CS = 1'b1;
  assign sram_RE = rd_go;
  assign sram_R_ADDR = rd_word[GLB_WORD_AW-1:0];
  assign sram_W_ADDR = clr_busy ? clr_word : wr_word[GLB_WORD_AW-1:0];
  assign sram_WEB = ~(wr_go | clr_go);
  assign sram_BWEB = clr_go ? '0 : (wr_go ? bus.BWEB : '1);
  assign sram_D_IN = clr_busy ? '0 : bus.glb_write_data;
  // the macro returns pre-write data on a same-cycle collision, so remember the write to merge it in
  assign byp_d = rd_go & ~sram_WEB & (sram_W_ADDR == sram_R_ADDR);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      roob_q <= 1'b0;
      byp_q <= 1'b0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
      err_q <= 1'b0;
    end else begin
      rvalid_q <= rd_go;
      roob_q <= rd_oob;
      byp_q <= byp_d;
      byp_data_q <= sram_D_IN;
      byp_mask_q <= sram_BWEB;
      err_q <= err_q | err_d;
    end
  end
  assign bus.glb_read_valid = rvalid_q;
  assign bus.glb_read_data = (rvalid_q & ~roob_q)
    ? (byp_q ? ((sram_D_OUT & byp_mask_q) | (byp_data_q & ~byp_mask_q)) : sram_D_OUT) : '0;
  assign bus.glb_write_ready = ~clr_busy;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;
  assign err_addr = err_q;
endmodule

// File: tb/tb_glb_responder.sv
// tb_glb_responder: scoreboard bench with a behavioural 1-cycle SRAM and a shadow memory model
module tb_glb_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  glb_if #(.AW(32), .DW(32)) bus ();
  logic sram_CS, sram_WEB, sram_RE, err_addr;
  logic [31:0] sram_BWEB, sram_D_IN, sram_D_OUT;
  logic [13:0] sram_R_ADDR, sram_W_ADDR;
  glb_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16384)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sram_CS(sram_CS),
    .sram_WEB(sram_WEB),
    .sram_BWEB(sram_BWEB),
    .sram_RE(sram_RE),
    .sram_R_ADDR(sram_R_ADDR),
    .sram_W_ADDR(sram_W_ADDR),
    .sram_D_IN(sram_D_IN),
    .sram_D_OUT(sram_D_OUT),
    .err_addr(err_addr)
  );
  logic [31:0] mem [16384];
  logic [31:0] exp_mem [16384];
  logic [31:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk) begin
    if (sram_RE) sram_D_OUT <= mem[sram_R_ADDR];
    if (!sram_WEB) mem[sram_W_ADDR] <= (mem[sram_W_ADDR] & sram_BWEB) | (sram_D_IN & ~sram_BWEB);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (rst && bus.glb_read_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", bus.glb_read_valid, 0);
      else chk("rd_data", bus.glb_read_data, exp_q.pop_front());
    end
  end
  task automatic idle();
    bus.glb_read_ready = 0;
    bus.glb_read_addr = '0;
    bus.glb_write_valid = 0;
    bus.glb_write_addr = '0;
    bus.glb_write_data = '0;
    bus.WEB = 1;
    bus.BWEB = '1;
    bus.clr_start = 0;
    bus.clr_base = '0;
    bus.clr_words = '0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    bus.glb_write_valid = 1;
    bus.WEB = 0;
    bus.glb_write_addr = a;
    bus.glb_write_data = d;
    bus.BWEB = m;
    if ((a >> 2) < 16384) exp_mem[a[15:2]] = (exp_mem[a[15:2]] & m) | (d & ~m);
  endtask
  task automatic rd(input logic [31:0] a);
    bus.glb_read_ready = 1;
    bus.glb_read_addr = a;
    exp_q.push_back(((a >> 2) < 16384) ? exp_mem[a[15:2]] : 32'h0);
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    nxt();
    wr(a, d, 32'h0);
  endtask
  task automatic start_clr(input logic [31:0] base, input logic [15:0] words);
    bus.clr_start = 1;
    bus.clr_base = base;
    bus.clr_words = words;
  endtask
  initial begin
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.glb_read_valid, 0);
    chk("rst_data", bus.glb_read_data, 0);
    chk("rst_wready", bus.glb_write_ready, 1);
    chk("rst_busy", bus.clr_busy, 0);
    chk("rst_done", bus.clr_done, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_web", sram_WEB, 1);
    chk("rst_re", sram_RE, 0);
    chk("rst_bweb", sram_BWEB, 32'hFFFF_FFFF);
    chk("rst_cs", sram_CS, 1);
    rst = 1;
    load(32'h400, 32'hDEAD_BEEF);
    load(32'h3A98, 32'hAAAA_AAAA);
    load(32'h0, 32'h1234_5678);
    for (int i = 1; i < 4; i++) load((3750 + i) * 4, 32'h5A5A_0000 + i);
    load(64 * 4, 32'h0BAD_F00D);
    // read latency: response exactly one cycle after the request
    nxt();
    rd(32'h400);
    @(negedge clk);
    chk("rd_re", sram_RE, 1);
    chk("rd_raddr", sram_R_ADDR, 256);
    chk("rd_lat0", bus.glb_read_valid, 0);
    nxt();
    @(negedge clk);
    chk("rd_lat1", bus.glb_read_valid, 1);
    nxt();
    @(negedge clk);
    chk("rd_lat2", bus.glb_read_valid, 0);
    // same-cycle partial write and read of one word
    nxt();
    wr(32'h3A98, 32'h1122_3344, 32'hFFFF_0000);
    rd(32'h3A98);
    @(negedge clk);
    chk("raw_web", sram_WEB, 0);
    chk("raw_waddr", sram_W_ADDR, 3750);
    chk("raw_bweb", sram_BWEB, 32'hFFFF_0000);
    chk("raw_din", sram_D_IN, 32'h1122_3344);
    nxt();
    bus.glb_write_valid = 1;
    bus.glb_write_addr = 32'h400;
    @(negedge clk);
    chk("web_hi_nowrite", sram_WEB, 1);
    chk("err_clean", err_addr, 0);
    nxt();
    rd(32'h401);
    nxt();
    @(negedge clk);
    chk("err_misalign", err_addr, 1);
    nxt();
    @(negedge clk);
    chk("err_sticky", err_addr, 1);
    nxt();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("err_rst", err_addr, 0);
    // out-of-range write then read
    nxt();
    wr(32'h10000, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    chk("oob_web", sram_WEB, 1);
    nxt();
    rd(32'h10000);
    @(negedge clk);
    chk("oob_err", err_addr, 1);
    nxt();
    @(negedge clk);
    chk("oob_valid", bus.glb_read_valid, 1);
    nxt();
    rd(32'h0);
    nxt();
    nxt();
    // zero-length clear goes straight to done
    start_clr(32'h2000, 16'd0);
    @(negedge clk);
    chk("clr0_busy_pre", bus.clr_busy, 0);
    nxt();
    @(negedge clk);
    chk("clr0_done", bus.clr_done, 1);
    chk("clr0_busy", bus.clr_busy, 0);
    nxt();
    @(negedge clk);
    chk("clr0_done_off", bus.clr_done, 0);
    // four-word clear with a colliding read and an ignored restart
    nxt();
    start_clr(32'd15000, 16'd4);
    for (int i = 0; i < 4; i++) exp_mem[3750 + i] = 32'h0;
    @(negedge clk);
    chk("clr_idle_ready", bus.glb_write_ready, 1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (i == 1) rd(3751 * 4);
      if (i == 2) start_clr(32'h0, 16'd9);
      @(negedge clk);
      chk("clr_busy", bus.clr_busy, 1);
      chk("clr_wready", bus.glb_write_ready, 0);
      chk("clr_web", sram_WEB, 0);
      chk("clr_waddr", sram_W_ADDR, 3750 + i);
      chk("clr_bweb", sram_BWEB, 32'h0);
      chk("clr_din", sram_D_IN, 32'h0);
      chk("clr_done_early", bus.clr_done, 0);
    end
    nxt();
    @(negedge clk);
    chk("clr_done", bus.clr_done, 1);
    chk("clr_busy_off", bus.clr_busy, 0);
    chk("clr_wready_back", bus.glb_write_ready, 1);
    nxt();
    @(negedge clk);
    chk("clr_done_pulse", bus.clr_done, 0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      rd((3750 + i) * 4);
    end
    nxt();
    rd(32'h0);
    nxt();
    nxt();
    // reset on the second clear cycle aborts the clear
    start_clr(64 * 4, 16'd8);
    exp_mem[64] = 32'h0;
    nxt();
    @(negedge clk);
    chk("abort_busy", bus.clr_busy, 1);
    nxt();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("abort_idle", bus.clr_busy, 0);
    chk("abort_wready", bus.glb_write_ready, 1);
    chk("abort_nodone", bus.clr_done, 0);
    nxt();
    @(negedge clk);
    chk("abort_nodone2", bus.clr_done, 0);
    rd(64 * 4);
    nxt();
    nxt();
    // streaming reads without bubbles
    for (int i = 0; i < 168; i++) load((1000 + i) * 4, $urandom);
    for (int i = 0; i < 168; i++) begin
      nxt();
      rd((1000 + i) * 4);
      @(negedge clk);
      if (i > 0) chk("stream_gap", bus.glb_read_valid, 1);
    end
    nxt();
    @(negedge clk);
    chk("stream_last", bus.glb_read_valid, 1);
    nxt();
    // clear running off the end of the array
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    nxt();
    start_clr(32'd65528, 16'd4);
    exp_mem[16382] = 32'h0;
    exp_mem[16383] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      @(negedge clk);
      chk("clre_busy", bus.clr_busy, 1);
      chk("clre_web", sram_WEB, (i < 2) ? 0 : 1);
      if (i < 2) chk("clre_waddr", sram_W_ADDR, 16382 + i);
      chk("clre_err", err_addr, (i < 3) ? 0 : 1);
    end
    nxt();
    @(negedge clk);
    chk("clre_done", bus.clr_done, 1);
    rd(32'h0);
    nxt();
    rd(32'd65532);
    nxt();
    nxt();
    nxt();
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
